pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline. It drives the freeze and flush inputs of the IF/ID and ID/EXE pipeline registers. It detects RAW hazards between ID sources and EXE/MEM destinations, converts a taken branch from EXE into flushes, and runs a memory-wait FSM that freezes the whole pipeline while the data memory is busy.

Parameters:
REG_W, 4, register index width
MEM_TIMEOUT, 255, max wait cycles in WAIT before the error state
CNT_W, 16, width of the stall statistics counter

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous, active-high reset
id_src1  in  REG_W  ID-stage source register 1
id_src2  in  REG_W  ID-stage source register 2
id_use_src1  in  1  ID instruction reads src1
id_use_src2  in  1  ID instruction reads src2
exe_wb_en  in  1  EXE instruction writes back
exe_dest  in  REG_W  EXE destination
exe_mem_read  in  1  EXE instruction is a load
mem_wb_en  in  1  MEM instruction writes back
mem_dest  in  REG_W  MEM destination
branch_taken  in  1  branch resolved taken in EXE
mem_req  in  1  MEM stage is accessing data memory
mem_ready  in  1  data memory access complete
freeze_if  out  1  hold PC and IF/ID register
flush_if  out  1  clear IF/ID register
flush_id  out  1  clear ID/EXE register (bubble insert)
freeze_all  out  1  hold every pipeline register (memory wait)
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  saturating count of freeze cycles

Behaviour:
- Reset (synchronous, rst=1 at clk edge): FSM=IDLE, wait counter=0, mem_err=0, stall_cnt=0.
- The combinational outputs follow from the reset state: freeze_if=0, flush_if=0, flush_id=0, freeze_all=0.
- rst asserted mid-WAIT aborts the wait and returns to IDLE on that edge.
- RAW hazard (combinational), without FORWARDING_EN: haz = (use1 & ((exe_wb_en & src1==exe_dest) | (mem_wb_en & src1==mem_dest))) | the same term for src2.
- Memory FSM states:
  - IDLE: mem_req & !mem_ready -> WAIT, wait counter cleared. mem_req & mem_ready -> stay IDLE; the single-cycle access causes no stall.
  - WAIT: counter increments each cycle. mem_ready -> IDLE. If counter==MEM_TIMEOUT-1 and !mem_ready -> ERR. mem_ready on the timeout cycle wins, so the FSM returns to IDLE.
  - ERR: mem_err=1 and freeze_all=1 permanently until rst.
- mem_stall = (state==IDLE & mem_req & !mem_ready) | state==WAIT | state==ERR. The stall is combinational on entry, so there is zero-cycle latency from mem_req.
- freeze_all = mem_stall.
- Priority: mem_stall > branch_taken > haz.
  - mem_stall=1: freeze_all=1, freeze_if=1, flush_if=0, flush_id=0. A pending branch stays in the frozen EXE register and is flushed in the first cycle after release.
  - branch_taken=1 (no mem_stall): flush_if=1, flush_id=1, freeze_if=0. Freeze must be low because a register freeze would override the flush.
  - haz=1 only: freeze_if=1, flush_id=1, flush_if=0.
- stall_cnt increments on every cycle where freeze_if|freeze_all. It saturates at all-ones and never wraps.
- Outputs are glitch-free relative to clk only; consumers sample on the clock edge.

Optional Feature:
FORWARDING_EN
- Defined: the forwarding unit resolves ALU results. haz reduces to the load-use case: exe_mem_read & exe_wb_en & ((use1 & src1==exe_dest) | (use2 & src2==exe_dest)). MEM-stage matches never stall.
- Undefined: the full RAW equation above applies.
- The FSM, branch handling and counter are identical in both builds.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum IDLE/WAIT/ERR (2-bit encoding 00/01/10)
  - the REG_W default constant
  - the MEM_TIMEOUT default constant
- One sub-module, hazard_detect, is natural: the purely combinational RAW/load-use compare, with the FORWARDING_EN switch inside it.
- The FSM, priority muxing and counter stay in the top module.

Test Plan:
- Reset mid-WAIT: mem_req=1, mem_ready=0 for 3 cycles, then rst=1 for 1 cycle -> next cycle state IDLE, freeze_all=0, stall_cnt=0.
- RAW without FORWARDING_EN: id_src1=3, use1=1, mem_wb_en=1, mem_dest=3 -> freeze_if=1, flush_id=1, flush_if=0. With FORWARDING_EN -> all three 0.
- Load-use with FORWARDING_EN: exe_mem_read=1, exe_wb_en=1, exe_dest=5, id_src2=5, use2=1 -> freeze_if=1, flush_id=1 for exactly one cycle once EXE advances.
- Branch plus hazard in the same cycle: branch_taken=1 and haz=1 -> flush_if=1, flush_id=1, freeze_if=0.
- Branch during memory wait: mem_req=1 with mem_ready=0 for 4 cycles while branch_taken=1 -> freeze_all=1 and flush_if=0 for 4 cycles. When mem_ready=1, the next cycle gives flush_if=1, flush_id=1.
- Timeout with MEM_TIMEOUT=8: mem_req=1, mem_ready never asserted -> mem_err=1 after the 8th WAIT cycle. It stays 1 with mem_ready=1 until rst.
- Counter saturation with CNT_W=4: hold haz=1 for 20 cycles -> stall_cnt=15, held there.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
//   mem_state_e     : memory-wait FSM state (IDLE=00, WAIT=01, ERR=10)
//   REG_W_DEF       : default register index width
//   MEM_TIMEOUT_DEF : default number of WAIT cycles before the error state
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    ERR  = 2'b10
  } mem_state_e;

  localparam int unsigned REG_W_DEF       = 4;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
//   slave  : controller view (hazard/branch/memory status in, freeze/flush out)
//   master : datapath view (drives status, receives freeze/flush controls)
interface pipeline_hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF,
  parameter int unsigned CNT_W = 16
);
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_use_src1;
  logic             id_use_src2;
  logic             exe_wb_en;
  logic [REG_W-1:0] exe_dest;
  logic             exe_mem_read;
  logic             mem_wb_en;
  logic [REG_W-1:0] mem_dest;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             freeze_if;
  logic             flush_if;
  logic             flush_id;
  logic             freeze_all;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  id_src1, id_src2, id_use_src1, id_use_src2,
           exe_wb_en, exe_dest, exe_mem_read, mem_wb_en, mem_dest,
           branch_taken, mem_req, mem_ready,
    output freeze_if, flush_if, flush_id, freeze_all, mem_err, stall_cnt
  );

  modport master (
    output id_src1, id_src2, id_use_src1, id_use_src2,
           exe_wb_en, exe_dest, exe_mem_read, mem_wb_en, mem_dest,
           branch_taken, mem_req, mem_ready,
    input  freeze_if, flush_if, flush_id, freeze_all, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Combinational RAW / load-use hazard compare for the ID stage.
// Build option: define FORWARDING_EN to reduce the check to load-use only
// (forwarding covers every other case, MEM-stage matches never stall).
//   id_src1_i/id_src2_i, id_use_src1_i/id_use_src2_i : ID sources and their use
//   exe_wb_en_i, exe_dest_i, exe_mem_read_i          : EXE writer
//   mem_wb_en_i, mem_dest_i                          : MEM writer
//   haz_o                                            : hazard present
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] id_src1_i,
  input  logic [REG_W-1:0] id_src2_i,
  input  logic             id_use_src1_i,
  input  logic             id_use_src2_i,
  input  logic             exe_wb_en_i,
  input  logic [REG_W-1:0] exe_dest_i,
  input  logic             exe_mem_read_i,
  input  logic             mem_wb_en_i,
  input  logic [REG_W-1:0] mem_dest_i,
  output logic             haz_o
);
  logic exe_hit;
  logic mem_hit;

  assign exe_hit = exe_wb_en_i &
                   ((id_use_src1_i & (id_src1_i == exe_dest_i)) |
                    (id_use_src2_i & (id_src2_i == exe_dest_i)));
  assign mem_hit = mem_wb_en_i &
                   ((id_use_src1_i & (id_src1_i == mem_dest_i)) |
                    (id_use_src2_i & (id_src2_i == mem_dest_i)));

`ifdef FORWARDING_EN
  logic unused_mem_hit;
  assign unused_mem_hit = mem_hit;
  assign haz_o = exe_mem_read_i & exe_hit;
`else
  logic unused_mem_read;
  assign unused_mem_read = exe_mem_read_i;
  assign haz_o = exe_hit | mem_hit;
`endif
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Build option: FORWARDING_EN (see hazard_detect) selects load-use-only hazards.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport of pipeline_hazard_ctrl_if carrying
//              hazard/branch/memory status in and freeze_if, flush_if,
//              flush_id, freeze_all, mem_err, stall_cnt out
// Priority: memory stall > taken branch > data hazard.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_W       = REG_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  mem_state_e        state_q;
  logic [WAIT_W-1:0] wait_q;
  logic              mem_err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              haz;
  logic              mem_stall;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_src1_i      (bus.id_src1),
    .id_src2_i      (bus.id_src2),
    .id_use_src1_i  (bus.id_use_src1),
    .id_use_src2_i  (bus.id_use_src2),
    .exe_wb_en_i    (bus.exe_wb_en),
    .exe_dest_i     (bus.exe_dest),
    .exe_mem_read_i (bus.exe_mem_read),
    .mem_wb_en_i    (bus.mem_wb_en),
    .mem_dest_i     (bus.mem_dest),
    .haz_o          (haz)
  );

  // Stall asserts in the same cycle as a missed request, not one cycle later.
  assign mem_stall = ((state_q == IDLE) & bus.mem_req & ~bus.mem_ready) |
                     (state_q != IDLE);

  // Freeze is kept low on a branch: a register freeze would mask the flush.
  always_comb begin
    bus.freeze_all = mem_stall;
    bus.freeze_if  = mem_stall | (~bus.branch_taken & haz);
    bus.flush_if   = ~mem_stall & bus.branch_taken;
    bus.flush_id   = ~mem_stall & (bus.branch_taken | haz);
  end

  assign bus.mem_err   = mem_err_q;
  assign bus.stall_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.mem_req & ~bus.mem_ready) begin
            state_q <= WAIT;
            wait_q  <= '0;
          end
        end
        WAIT: begin
          // mem_ready on the final wait cycle still completes the access.
          if (bus.mem_ready) begin
            state_q <= IDLE;
          end else if (wait_q == WAIT_LAST) begin
            state_q   <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ERR: begin
          mem_err_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if ((bus.freeze_if | bus.freeze_all) & ~(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;
  localparam int unsigned REG_W       = 4;
  localparam int unsigned MEM_TIMEOUT = 8;
  localparam int unsigned CNT_W       = 4;
  localparam int          CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .REG_W      (REG_W),
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: memory wait tracked as "waiting for N cycles".
  bit m_waiting = 0;
  int m_wait_n  = 0;
  bit m_err     = 0;
  int m_cnt     = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_haz();
    bit e1, e2, m1, m2;
    e1 = bus.id_use_src1 && bus.exe_wb_en && (bus.id_src1 == bus.exe_dest);
    e2 = bus.id_use_src2 && bus.exe_wb_en && (bus.id_src2 == bus.exe_dest);
    m1 = bus.id_use_src1 && bus.mem_wb_en && (bus.id_src1 == bus.mem_dest);
    m2 = bus.id_use_src2 && bus.mem_wb_en && (bus.id_src2 == bus.mem_dest);
`ifdef FORWARDING_EN
    return bus.exe_mem_read && (e1 || e2);
`else
    return e1 || e2 || m1 || m2;
`endif
  endfunction

  task automatic clear_inputs();
    bus.id_src1 = '0; bus.id_src2 = '0;
    bus.id_use_src1 = 1'b0; bus.id_use_src2 = 1'b0;
    bus.exe_wb_en = 1'b0; bus.exe_dest = '0; bus.exe_mem_read = 1'b0;
    bus.mem_wb_en = 1'b0; bus.mem_dest = '0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    rst = 1'b0;
  endtask

  // One clock: check combinational outputs mid-cycle, advance model on the
  // edge, check registered outputs just after it.
  task automatic step();
    bit ms, hz, br, f_if, f_all;
    @(negedge clk);
    ms = m_err || m_waiting || (bus.mem_req && !bus.mem_ready);
    hz = model_haz();
    br = bus.branch_taken;
    f_all = ms;
    f_if  = ms || (!br && hz);
    check("freeze_all", int'(bus.freeze_all), int'(f_all));
    check("freeze_if",  int'(bus.freeze_if),  int'(f_if));
    check("flush_if",   int'(bus.flush_if),   int'(!ms && br));
    check("flush_id",   int'(bus.flush_id),   int'(!ms && (br || hz)));
    @(posedge clk);
    if (rst) begin
      m_waiting = 0; m_wait_n = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (f_if || f_all) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      if (m_waiting) begin
        m_wait_n++;
        if (bus.mem_ready) m_waiting = 0;
        else if (m_wait_n == MEM_TIMEOUT) begin
          m_waiting = 0; m_err = 1;
        end
      end else if (!m_err && bus.mem_req && !bus.mem_ready) begin
        m_waiting = 1; m_wait_n = 0;
      end
    end
    #1;
    check("mem_err",   int'(bus.mem_err),   int'(m_err));
    check("stall_cnt", int'(bus.stall_cnt), m_cnt);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    rst = 1'b0;
    check("reset_cnt", int'(bus.stall_cnt), 0);
    check("reset_err", int'(bus.mem_err), 0);

    // Reset in the middle of a memory wait
    bus.mem_req = 1'b1;
    repeat (3) step();
    rst = 1'b1; step();
    clear_inputs(); step();
    check("rst_wait_freeze_all", int'(bus.freeze_all), 0);

    // RAW against MEM stage
    do_reset();
    bus.id_src1 = 4'd3; bus.id_use_src1 = 1'b1;
    bus.mem_wb_en = 1'b1; bus.mem_dest = 4'd3;
    step();

    // Load-use against EXE, one cycle, then EXE advances
    clear_inputs();
    bus.exe_mem_read = 1'b1; bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd5;
    bus.id_src2 = 4'd5; bus.id_use_src2 = 1'b1;
    step();
    bus.exe_mem_read = 1'b0; bus.exe_wb_en = 1'b0;
    step();

    // Branch together with a hazard
    bus.exe_wb_en = 1'b1; bus.branch_taken = 1'b1;
    step();

    // Branch held during a memory wait, flushed after release
    clear_inputs();
    bus.branch_taken = 1'b1; bus.mem_req = 1'b1;
    repeat (4) step();
    bus.mem_ready = 1'b1; step();
    bus.mem_req = 1'b0; bus.mem_ready = 1'b0; step();

    // Timeout into the sticky error state
    do_reset();
    bus.mem_req = 1'b1;
    repeat (MEM_TIMEOUT + 2) step();
    bus.mem_ready = 1'b1;
    repeat (3) step();
    check("err_sticky", int'(bus.mem_err), 1);
    do_reset();

    // Saturating stall counter
    bus.id_src1 = 4'd7; bus.id_use_src1 = 1'b1;
    bus.exe_wb_en = 1'b1; bus.exe_dest = 4'd7; bus.exe_mem_read = 1'b1;
    repeat (20) step();
    check("cnt_saturated", int'(bus.stall_cnt), CNT_MAX);
    do_reset();

    // Randomized traffic with small register space to provoke matches
    for (int i = 0; i < 800; i++) begin
      bus.id_src1      = REG_W'($urandom_range(0, 3));
      bus.id_src2      = REG_W'($urandom_range(0, 3));
      bus.id_use_src1  = 1'($urandom_range(0, 1));
      bus.id_use_src2  = 1'($urandom_range(0, 1));
      bus.exe_wb_en    = 1'($urandom_range(0, 1));
      bus.exe_dest     = REG_W'($urandom_range(0, 3));
      bus.exe_mem_read = 1'($urandom_range(0, 1));
      bus.mem_wb_en    = 1'($urandom_range(0, 1));
      bus.mem_dest     = REG_W'($urandom_range(0, 3));
      bus.branch_taken = ($urandom_range(0, 3) == 0);
      bus.mem_req      = ($urandom_range(0, 2) == 0);
      bus.mem_ready    = ($urandom_range(0, 9) < 3);
      rst              = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
